// File: rtl/hp0_axi_burst_writer_if.sv
// HP0 AXI4 write-side bundle (AW/W/B) between the burst writer and the Zynq shell.
// The master drives AW/W and bready; the slave drives the ready/response side.
interface hp0_axi_burst_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 6
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     awid;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awqos;

  logic [DATA_W-1:0]   wdata;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     wid;
  logic                wlast;
  logic [DATA_W/8-1:0] wstrb;

  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;

  modport master (
    output awaddr, awvalid, awid, awlock, awcache,
    output awprot, awlen, awsize, awburst, awqos,
    input  awready,
    output wdata, wvalid, wid, wlast, wstrb,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  awaddr, awvalid, awid, awlock, awcache,
    input  awprot, awlen, awsize, awburst, awqos,
    output awready,
    input  wdata, wvalid, wid, wlast, wstrb,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/hp0_axi_burst_writer.sv
// Write-only AXI4 burst master for HP0: splits a command into INCR bursts
// capped by max_burst_p and by 4 KB pages, one burst outstanding at a time.
module hp0_axi_burst_writer #(
  parameter int C_HP0_AXI_DATA_WIDTH = 32,
  parameter int C_HP0_AXI_ADDR_WIDTH = 32,
  parameter int max_burst_p          = 16,
  parameter int len_width_p          = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            cmd_v_i,
  input  logic [C_HP0_AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [len_width_p-1:0]          cmd_words_i,
  output logic                            cmd_ready_o,
  input  logic [C_HP0_AXI_DATA_WIDTH-1:0] data_i,
  input  logic                            data_v_i,
  output logic                            data_ready_o,
  output logic                            done_o,
  output logic                            err_o,
  hp0_axi_burst_writer_if.master          hp0_axi
);
  localparam int A     = C_HP0_AXI_ADDR_WIDTH;
  localparam int L     = len_width_p;
  localparam int BYTES = C_HP0_AXI_DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int CW    = (L > 13) ? L : 13;
  localparam logic [A-1:0] AMASK = ~A'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_AW, S_W, S_B
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   addr_q;
  logic [L-1:0]   rem_q;
  logic [8:0]     beat_q;
  logic           err_flag_q;
  logic           done_q;
  logic           err_q;

  logic [12:0]    page_beats;
  logic [CW-1:0]  beats_x;
  logic [8:0]     beats;
  logic           accept;
  logic           w_fire;
  logic           last_beat;
  logic           b_fire;
  logic           b_err;
  logic           unused_bits;

  // Burst size depends only on addr_q/rem_q, which hold still through AW and W
  always_comb begin
    page_beats = (13'h1000 - {1'b0, addr_q[11:0]}) >> SZ;
    beats_x    = CW'(rem_q);
    if (CW'(max_burst_p) < beats_x) beats_x = CW'(max_burst_p);
    if (CW'(page_beats) < beats_x)  beats_x = CW'(page_beats);
  end

  assign beats       = beats_x[8:0];
  assign unused_bits = ^{hp0_axi.bid, beats_x[CW-1:9]};

  assign cmd_ready_o = (state_q == S_IDLE) & ~done_q;
  assign accept      = cmd_v_i & cmd_ready_o;
  assign w_fire      = (state_q == S_W) & data_v_i & hp0_axi.wready;
  assign last_beat   = (beat_q == beats - 9'd1);
  assign b_fire      = (state_q == S_B) & hp0_axi.bvalid;
  assign b_err       = (hp0_axi.bresp != 2'b00);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept && cmd_words_i != '0) state_d = S_AW;
      S_AW:
        if (hp0_axi.awready) state_d = S_W;
      S_W:
        if (w_fire && last_beat) state_d = S_B;
      S_B:
        if (hp0_axi.bvalid)
          state_d = (rem_q == L'(beats)) ? S_IDLE : S_AW;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beat_q     <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        addr_q     <= cmd_addr_i & AMASK;
        rem_q      <= cmd_words_i;
        err_flag_q <= 1'b0;
        if (cmd_words_i == '0) done_q <= 1'b1;
      end
      if (state_q == S_AW && hp0_axi.awready) beat_q <= '0;
      if (w_fire) beat_q <= beat_q + 9'd1;
      if (b_fire) begin
        addr_q <= addr_q + (A'(beats) << SZ);
        rem_q  <= rem_q - L'(beats);
        if (b_err) err_flag_q <= 1'b1;
        if (rem_q == L'(beats)) begin
          done_q <= 1'b1;
          err_q  <= err_flag_q | b_err;
        end
      end
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;

  assign hp0_axi.awvalid = (state_q == S_AW);
  assign hp0_axi.awaddr  = hp0_axi.awvalid ? addr_q : '0;
  assign hp0_axi.awlen   = hp0_axi.awvalid ? 8'(beats - 9'd1) : 8'd0;
  assign hp0_axi.awsize  = 3'(SZ);
  assign hp0_axi.awburst = 2'b01;
  assign hp0_axi.awcache = 4'b0011;
  assign hp0_axi.awprot  = 3'b000;
  assign hp0_axi.awlock  = 1'b0;
  assign hp0_axi.awqos   = 4'b0000;
  assign hp0_axi.awid    = '0;

  assign hp0_axi.wvalid  = (state_q == S_W) & data_v_i;
  assign data_ready_o    = (state_q == S_W) & hp0_axi.wready;
  assign hp0_axi.wdata   = data_i;
  assign hp0_axi.wstrb   = '1;
  assign hp0_axi.wid     = '0;
  assign hp0_axi.wlast   = (state_q == S_W) & last_beat;

  assign hp0_axi.bready  = (state_q == S_B);
endmodule

// File: tb/tb_hp0_axi_burst_writer.sv
// Directed bench for hp0_axi_burst_writer: a small burst-split model predicts
// every AW, W beat and completion; the bench plays the HP0 slave.
module tb_hp0_axi_burst_writer;
  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_v;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_words;
  logic        cmd_ready;
  logic [31:0] data;
  logic        data_v;
  logic        data_ready;
  logic        done;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;
  int gw       = 0;

  always #5 clk = ~clk;

  hp0_axi_burst_writer_if #(.DATA_W(32), .ADDR_W(32)) hp0_axi ();

  hp0_axi_burst_writer #(
    .C_HP0_AXI_DATA_WIDTH(32),
    .C_HP0_AXI_ADDR_WIDTH(32),
    .max_burst_p(16),
    .len_width_p(16)
  ) dut (
    .aclk(clk),
    .aresetn(aresetn),
    .cmd_v_i(cmd_v),
    .cmd_addr_i(cmd_addr),
    .cmd_words_i(cmd_words),
    .cmd_ready_o(cmd_ready),
    .data_i(data),
    .data_v_i(data_v),
    .data_ready_o(data_ready),
    .done_o(done),
    .err_o(err),
    .hp0_axi(hp0_axi)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_slave();
    hp0_axi.awready = 1'b0;
    hp0_axi.wready  = 1'b0;
    hp0_axi.bvalid  = 1'b0;
    hp0_axi.bresp   = 2'b00;
    hp0_axi.bid     = '0;
    data_v          = 1'b0;
    cmd_v           = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_awvalid"},   hp0_axi.awvalid, 0);
    check({p, "_wvalid"},    hp0_axi.wvalid, 0);
    check({p, "_wlast"},     hp0_axi.wlast, 0);
    check({p, "_bready"},    hp0_axi.bready, 0);
    check({p, "_dready"},    data_ready, 0);
    check({p, "_done"},      done, 0);
    check({p, "_err"},       err, 0);
    check({p, "_awaddr"},    hp0_axi.awaddr, 0);
    check({p, "_awlen"},     hp0_axi.awlen, 0);
    check({p, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic do_cmd(input logic [31:0] a, input int words,
                        input bit stall, input int bad,
                        input int abort_at);
    logic [31:0] ea;
    logic [31:0] exp_addr[$];
    int          exp_len[$];
    int          rem, b, pg, nb;
    int          aw_i, w_i, beat, b_i;
    bit          aw_done, b_pend, stalled, last_prev, got_done, exp_err;
    logic [31:0] sv_addr;
    logic [7:0]  sv_len;

    ea  = a & ~32'h3;
    rem = words;
    while (rem > 0) begin
      pg = (4096 - int'(ea[11:0])) / 4;
      b  = rem;
      if (b > 16) b = 16;
      if (b > pg) b = pg;
      exp_addr.push_back(ea);
      exp_len.push_back(b - 1);
      ea  = ea + 32'(b * 4);
      rem = rem - b;
    end
    nb      = exp_addr.size();
    exp_err = (bad >= 0) && (bad < nb);
    aw_i = 0; w_i = 0; beat = 0; b_i = 0;
    aw_done = 0; b_pend = 0; stalled = 0;
    last_prev = 0; got_done = 0;
    sv_addr = '0; sv_len = '0;

    @(negedge clk);
    cmd_v     = 1'b1;
    cmd_addr  = a;
    cmd_words = 16'(words);
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_v = 1'b0;

    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      hp0_axi.awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hp0_axi.wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      data_v          = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      data            = 32'hD000_0000 | 32'(gw);
      hp0_axi.bvalid  = b_pend &&
                        (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      hp0_axi.bresp   = (b_i == bad) ? 2'b10 : 2'b00;
      #1;
      if (cyc == 0) begin
        check("accept_to_aw", hp0_axi.awvalid, words > 0);
        if (words == 0) begin
          check("zero_done", done, 1);
          check("zero_err", err, 0);
        end
      end
      if (last_prev) check("w_to_bready", hp0_axi.bready, 1);
      last_prev = 0;
      if (stalled) begin
        check("aw_hold_valid", hp0_axi.awvalid, 1);
        check("aw_hold_addr", hp0_axi.awaddr, sv_addr);
        check("aw_hold_len", hp0_axi.awlen, sv_len);
      end
      stalled = 0;
      if (hp0_axi.awvalid) begin
        check("aw_extra", aw_i < nb, 1);
        check("aw_outstanding", aw_done | b_pend, 0);
        if (hp0_axi.awready) begin
          check("awaddr", hp0_axi.awaddr, exp_addr[aw_i]);
          check("awlen", hp0_axi.awlen, exp_len[aw_i]);
          check("awsize", hp0_axi.awsize, 2);
          check("awburst", hp0_axi.awburst, 1);
          check("awcache", hp0_axi.awcache, 3);
          aw_i++;
          aw_done = 1;
          beat    = 0;
        end else begin
          stalled = 1;
          sv_addr = hp0_axi.awaddr;
          sv_len  = hp0_axi.awlen;
        end
      end
      if (hp0_axi.wvalid) begin
        check("w_after_aw", aw_done, 1);
        if (hp0_axi.wready) begin
          check("wdata", hp0_axi.wdata, 32'hD000_0000 | 32'(gw));
          check("wstrb", hp0_axi.wstrb, 4'hF);
          check("wlast", hp0_axi.wlast, beat == exp_len[aw_i-1]);
          if (beat == exp_len[aw_i-1]) begin
            aw_done   = 0;
            b_pend    = 1;
            last_prev = 1;
          end
          beat++;
          w_i++;
          gw++;
        end
      end
      if (hp0_axi.bvalid && hp0_axi.bready) begin
        b_pend = 0;
        b_i++;
      end
      if (done) begin
        got_done = 1;
        check("done_err", err, exp_err);
        check("done_aw_count", aw_i, nb);
        check("done_beats", w_i, words);
        check("done_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk);
      @(negedge clk);
      if (abort_at >= 0 && w_i == abort_at) begin
        aresetn = 1'b0;
        #1 check_reset("mid_rst");
        idle_slave();
        @(negedge clk);
        aresetn = 1'b1;
        return;
      end
    end
    idle_slave();
    check("done_seen", got_done, 1);
    #1;
    check("cmd_ready_after", cmd_ready, 1);
    check("done_single", done, 0);
  endtask

  initial begin
    idle_slave();
    cmd_addr  = '0;
    cmd_words = '0;
    data      = '0;
    aresetn   = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset("reset");
    aresetn = 1'b1;

    do_cmd(32'h0000_1000, 4, 0, -1, -1);
    do_cmd(32'h0000_1000, 40, 0, -1, -1);
    do_cmd(32'h0000_1FF8, 6, 0, -1, -1);
    do_cmd(32'h0000_0040, 0, 0, -1, -1);
    do_cmd(32'h0000_3000, 20, 1, 1, -1);
    do_cmd(32'h0000_3100, 5, 1, -1, -1);
    do_cmd(32'hFFFF_FFF0, 8, 0, -1, -1);
    do_cmd(32'h0000_2000, 8, 0, -1, 3);
    do_cmd(32'h0000_5006, 10, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
